// File: rtl/matmul_seq_ctrl.sv
// Resource-shared matrix multiplier sequencer: streams in A and B, then reuses one 16x16
// multiplier and one accumulator for every C element, streaming C out row-major.
module matmul_seq_ctrl #(
   parameter int unsigned Col1 = 2,
   parameter int unsigned Row1 = 2,
   parameter int unsigned Row2 = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_last
);

   localparam int unsigned NumA = Col1 * Row1;
   localparam int unsigned NumW = NumA + Row1 * Row2;
   localparam int unsigned IdxW = $clog2(NumW);
   localparam int unsigned IW   = $clog2(Col1 + 1);
   localparam int unsigned JW   = $clog2(Row2 + 1);
   localparam int unsigned KW   = $clog2(Row1 + 1);

   localparam logic [IdxW-1:0] IdxLast = IdxW'(NumW - 1);
   localparam logic [IW-1:0]   ILast   = IW'(Col1 - 1);
   localparam logic [JW-1:0]   JLast   = JW'(Row2 - 1);
   localparam logic [KW-1:0]   KLast   = KW'(Row1 - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StMac, StEmit, StFin} state_e;

   state_e state_q, state_d;

   logic [IdxW-1:0] idx_q;
   logic [IW-1:0]   i_q;
   logic [JW-1:0]   j_q;
   logic [KW-1:0]   k_q;
   logic [15:0]     acc_q;
   logic [15:0]     mem_q [NumW];

   logic [IdxW-1:0] a_addr, b_addr;
   logic [15:0]     prod;
   logic            last_elem;

   // A occupies slots [0, NumA), B follows immediately after.
   assign a_addr    = IdxW'(32'(i_q) * Row1 + 32'(k_q));
   assign b_addr    = IdxW'(NumA + 32'(k_q) * Row2 + 32'(j_q));
   assign prod      = mem_q[a_addr] * mem_q[b_addr];
   assign last_elem = (i_q == ILast) && (j_q == JLast);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StLoad;
         StLoad: if (in_valid && idx_q == IdxLast) state_d = StMac;
         StMac:  if (k_q == KLast) state_d = StEmit;
         StEmit: if (out_ready) state_d = last_elem ? StFin : StMac;
         StFin:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StFin);
      in_ready  = (state_q == StLoad);
      out_valid = (state_q == StEmit);
      out_last  = out_valid && last_elem;
      out_data  = out_valid ? acc_q : 16'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         i_q   <= '0;
         j_q   <= '0;
         k_q   <= '0;
         acc_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  idx_q <= '0;
               end
            end
            StLoad: begin
               if (in_valid) begin
                  idx_q <= idx_q + IdxW'(1);
                  if (idx_q == IdxLast) begin
                     i_q <= '0;
                     j_q <= '0;
                     k_q <= '0;
                  end
               end
            end
            StMac: begin
               acc_q <= ((k_q == '0) ? 16'd0 : acc_q) + prod;
               if (k_q != KLast) begin
                  k_q <= k_q + KW'(1);
               end
            end
            StEmit: begin
               if (out_ready && !last_elem) begin
                  k_q <= '0;
                  if (j_q == JLast) begin
                     j_q <= '0;
                     i_q <= i_q + IW'(1);
                  end else begin
                     j_q <= j_q + JW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Operand storage carries no reset; contents are rewritten by every job.
   always_ff @(posedge clk) begin
      if (state_q == StLoad && in_valid) begin
         mem_q[idx_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: scoreboard of expected C elements checked at each output
// handshake, plus a second 2x3 * 3x1 instance checked inline.
module tb_matmul_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, busy, done, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [15:0] in_data, out_data;
   logic        start1, busy1, done1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
   logic [15:0] in_data1, out_data1;

   matmul_seq_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   matmul_seq_ctrl #(.Col1(2), .Row1(3), .Row2(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_last(out_last1)
   );

   int          total = 0, bad = 0;
   int          cyc = 0, out_count = 0, done_count = 0, first_v_cyc = -1;
   logic [16:0] exp_q [$];
   logic        fin_pend = 1'b0, stall_prev = 1'b0, prev_last = 1'b0;
   logic [15:0] prev_data = '0;
   logic        stall_mode = 1'b0;
   int          scnt = 0;
   logic [15:0] words [8];
   logic [15:0] w1 [9];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output monitor: pops the scoreboard on each handshake and checks stall stability and done.
   initial forever begin
      logic [16:0] e;
      @(negedge clk);
      if (!rst_n) begin
         fin_pend   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         check("done_timing", done, fin_pend);
         if (done) done_count++;
         if (stall_prev && out_valid) begin
            check("stall_data", out_data, prev_data);
            check("stall_last", out_last, prev_last);
         end
         if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
         if (out_valid && out_ready) begin
            check("q_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("c_data", out_data, e[15:0]);
               check("c_last", out_last, e[16]);
            end
            out_count++;
         end
         fin_pend   = out_valid && out_ready && out_last;
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic push_expected();
      logic [15:0] s;
      logic [31:0] p;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            s = 16'd0;
            for (int k = 0; k < 2; k++) begin
               p = words[i*2+k] * words[4+k*2+j];
               s = s + p[15:0];
            end
            exp_q.push_back({(i == 1 && j == 1), s});
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_words(input bit gaps, input bit start_in_gap);
      logic ok;
      for (int n = 0; n < 8; n++) begin
         in_valid = 1'b1;
         in_data  = words[n];
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            ok = in_ready;
            @(posedge clk); #1;
         end
         check("load_ready", ok, 1'b1);
         if (gaps) begin
            in_valid = 1'b0;
            in_data  = 16'hdead;
            if (start_in_gap && n == 3) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int base, n;
      base = done_count;
      n = 0;
      scnt = 0;
      while (done_count == base && n < budget) begin
         @(posedge clk); #1;
         if (stall_mode) begin
            if (out_valid) begin
               if (scnt < 5) begin
                  out_ready = 1'b0;
                  scnt++;
               end else begin
                  out_ready = 1'b1;
               end
            end else begin
               out_ready = 1'b0;
               scnt = 0;
            end
         end
         n++;
      end
      check("done_seen", done_count, base + 1);
      check("q_drained", exp_q.size(), 0);
   endtask

   initial begin
      int t0, n, base;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_out_data", out_data, 16'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 2x2 job with latency measurement.
      words = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4};
      push_expected();
      first_v_cyc = -1;
      t0 = cyc;
      pulse_start();
      check("busy_load", busy, 1'b1);
      load_words(1'b0, 1'b0);
      wait_done(100);
      check("first_valid_lat", first_v_cyc - t0, 11);
      @(posedge clk); #1;
      check("idle_busy", busy, 1'b0);

      // Truncation of product and sum to 16 bits.
      words = '{16'd300, 16'd0, 16'd0, 16'd0, 16'd300, 16'd0, 16'd0, 16'd0};
      exp_q.push_back({1'b0, 16'd24464});
      exp_q.push_back({1'b0, 16'd0});
      exp_q.push_back({1'b0, 16'd0});
      exp_q.push_back({1'b1, 16'd0});
      pulse_start();
      load_words(1'b0, 1'b0);
      wait_done(100);

      // Backpressure: 5 stalled cycles on every element.
      words = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4};
      push_expected();
      stall_mode = 1'b1;
      out_ready  = 1'b0;
      pulse_start();
      load_words(1'b0, 1'b0);
      wait_done(200);
      stall_mode = 1'b0;
      out_ready  = 1'b1;

      // Input gaps, plus start pulses during LOAD and MAC that must be ignored.
      words = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
      push_expected();
      base = done_count;
      pulse_start();
      load_words(1'b1, 1'b1);
      pulse_start();
      wait_done(100);
      repeat (10) @(posedge clk);
      #1;
      check("single_done", done_count, base + 1);
      check("no_requeue_busy", busy, 1'b0);

      // Reset while the second element is being accumulated.
      words = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4};
      push_expected();
      base = out_count;
      pulse_start();
      load_words(1'b0, 1'b0);
      n = 0;
      while (out_count == base && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("first_elem_out", out_count, base + 1);
      base = done_count;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_out_data", out_data, 16'd0);
      check("mid_rst_in_ready", in_ready, 1'b0);
      check("mid_rst_done", done, 1'b0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("no_done_after_rst", done_count, base);

      words = '{16'd1, 16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1};
      exp_q.push_back({1'b0, 16'd1});
      exp_q.push_back({1'b0, 16'd0});
      exp_q.push_back({1'b0, 16'd0});
      exp_q.push_back({1'b1, 16'd1});
      pulse_start();
      load_words(1'b0, 1'b0);
      wait_done(100);

      // Non-square 2x3 * 3x1 on the second instance.
      w1 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd1, 16'd1, 16'd1};
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int k = 0; k < 9; k++) begin
         check("ns_in_ready", in_ready1, 1'b1);
         in_valid1 = 1'b1;
         in_data1  = w1[k];
         @(posedge clk); #1;
      end
      in_valid1 = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_valid1 && n < 50);
      check("ns_mac_cycles0", n, 3);
      check("ns_c0", out_data1, 16'd6);
      check("ns_last0", out_last1, 1'b0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_valid1 && n < 50);
      check("ns_mac_cycles1", n, 4);
      check("ns_c1", out_data1, 16'd15);
      check("ns_last1", out_last1, 1'b1);
      @(posedge clk); #1;
      check("ns_done", done1, 1'b1);
      check("ns_busy_fin", busy1, 1'b1);
      @(posedge clk); #1;
      check("ns_done_drop", done1, 1'b0);
      check("ns_busy_drop", busy1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
